chrono_time_counter: RTL and testbench
======================================

Name: chrono_time_counter

Overview:
Downstream consumer of the chronometer start/stop/lap/reset state machine. Takes its 3-bit state code and reset_pulse and keeps a live MM:SS.cc time count in BCD. Produces a display value that freezes during lap states, plus a one-cycle update strobe for the LCD writer stage.

Parameters:
CLK_FREQ_HZ, 12000000, input clock frequency
TICK_HZ, 100, count resolution (centiseconds); divide ratio DIV = CLK_FREQ_HZ/TICK_HZ, must be an integer >= 2

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous, active-high reset
state  in  3  state code from state machine: 0 zero, 1 stopped, 2 running, 3 lap-running, 4 lap-stopped
reset_pulse  in  1  level from state machine; 1 = clear time
disp_bcd  out  24  displayed time {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4 bits each
running  out  1  1 while counting (state 2 or 3)
frozen  out  1  1 while display held (state 3 or 4)
disp_update  out  1  1-cycle pulse in the first cycle disp_bcd holds a new value
wrap  out  1  1-cycle pulse when live count passes 59:59.99

Behaviour:
- One clock; reset is synchronous and active-high (rst_in sampled on posedge clk_in).
- Reset values: live count 0, prescaler 0, disp_bcd 0, running 0, frozen 0, disp_update 0, wrap 0.
- running and frozen are registered decodes of state, 1 cycle latency.
- Priority per cycle: rst_in > clear > tick increment.
- Clear condition: reset_pulse==1 OR state==0. Zeroes the live count and the prescaler. No wrap pulse.
- Prescaler:
  - counts 0..DIV-1 only while state is 2 or 3; holds its value otherwise, so sub-tick time is preserved across stop/start.
  - tick asserts in the cycle the prescaler equals DIV-1; the prescaler then returns to 0.
- Live count: on tick, BCD increment with carries:
  - cs_u 9->0 carries to cs_t;
  - cs_t 9->0 carries to sec_u;
  - sec_u 9->0 carries to sec_t;
  - sec_t 5->0 carries to min_u;
  - min_u 9->0 carries to min_t;
  - min_t 5->0 = wrap.
  - No digit ever leaves its legal range.
- Wrap: 59:59.99 + tick -> 00:00.00 and wrap=1 for one cycle.
- Display:
  - when registered-decoded state is not 3/4: disp_bcd <= live every cycle (display lags live by 1 cycle);
  - when state is 3 or 4: disp_bcd holds.
  - Entering lap therefore freezes the value live had at the transition cycle. Leaving lap (3->2 or 4->1) resumes tracking on the next cycle.
- disp_update = 1 for exactly the cycle where disp_bcd differs from its previous-cycle value. It also fires on clear if disp was nonzero. No pulse is generated under rst_in.
- States 5-7 behave as state 0: clear, not counting, display tracks.
- rst_in mid-count returns all outputs to reset values next edge. The first tick after reset needs a full DIV cycles of counting.

Optional Feature:
Macro CHRONO_SATURATE_EN.
- Defined: at 59:59.99 the live count saturates. Further ticks are ignored, and wrap pulses once on the first ignored tick and never again until clear.
- Undefined: wrap-around as described above.

Decomposition:
- Package chrono_pkg holds:
  - state codes ST_ZERO=0, ST_STOP=1, ST_RUN=2, ST_LAP_RUN=3, ST_LAP_STOP=4;
  - digit width 4;
  - display width 24;
  - localparam helpers for digit limits (9, 5).
- One natural sub-module: bcd_digit_counter (parameter MAX_DIGIT; inputs clk_in, rst_in, clr, inc; outputs digit[3:0], carry). Instantiated 6 times, with the carry chain gating inc.

Test Plan:
Bench parameters CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset, then state=2 for 100 cycles -> disp_bcd=00:00.10 (0x000010) one cycle after the 10th tick; 10 disp_update pulses; running=1.
- Run to 00:01.23, set state=3 for 50 cycles -> disp_bcd stays 0x000123 and frozen=1, while live reaches 00:01.28; set state=2 -> next cycle disp_bcd=0x000128.
- Run 5 cycles into a tick period, state=1 for 200 cycles, then state=2 -> next tick arrives after exactly 5 more cycles; disp unchanged while stopped.
- From state 1 at 00:03.00, raise reset_pulse with state=0 -> disp_bcd=0x000000 with one disp_update pulse; running=0.
- Preload to 59:59.99 by running 359999 ticks, then one more tick -> 0x000000 with wrap=1 for one cycle. With CHRONO_SATURATE_EN: stays 0x595999, single wrap pulse.
- Assert rst_in while state=2 at 00:00.55 -> next cycle all outputs 0; state=5 after release -> count stays 0, running=0.

Source files
------------

// File: rtl/chrono_pkg.sv
// Shared state codes, digit limits and time layout for the chronometer time counter.
// Pure definitions: no latency, no flow control.
package chrono_pkg;

   localparam int DIGIT_W  = 4;
   localparam int DISP_W   = 24;
   localparam int N_DIGITS = 6;

   localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] SEX_MAX = 4'd5;

   typedef enum logic [2:0] {
      ST_ZERO     = 3'd0,
      ST_STOP     = 3'd1,
      ST_RUN      = 3'd2,
      ST_LAP_RUN  = 3'd3,
      ST_LAP_STOP = 3'd4
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] min_t;
      logic [DIGIT_W-1:0] min_u;
      logic [DIGIT_W-1:0] sec_t;
      logic [DIGIT_W-1:0] sec_u;
      logic [DIGIT_W-1:0] cs_t;
      logic [DIGIT_W-1:0] cs_u;
   } time_bcd_t;

   localparam time_bcd_t TIME_MAX = '{
      min_t: SEX_MAX, min_u: DEC_MAX,
      sec_t: SEX_MAX, sec_u: DEC_MAX,
      cs_t:  DEC_MAX, cs_u:  DEC_MAX
   };

   function automatic logic is_counting(input logic [2:0] s);
      return (s == ST_RUN) || (s == ST_LAP_RUN);
   endfunction

   function automatic logic is_frozen(input logic [2:0] s);
      return (s == ST_LAP_RUN) || (s == ST_LAP_STOP);
   endfunction

   // Codes above ST_LAP_STOP are undefined and treated like ST_ZERO.
   function automatic logic is_clear_state(input logic [2:0] s);
      return (s == ST_ZERO) || (s > ST_LAP_STOP);
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MAX_DIGIT with synchronous clear and carry-out.
// Digit updates on the edge after inc; carry is combinational; no backpressure.
module bcd_digit_counter
   import chrono_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX_DIGIT = DEC_MAX
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   logic at_max;

   // >= keeps an out-of-range value from ever counting further upward.
   assign at_max = (digit >= MAX_DIGIT);
   assign carry  = inc && at_max;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (inc) begin
         digit <= at_max ? '0 : digit + 1'b1;
      end
   end

endmodule

// File: rtl/chrono_time_counter.sv
// Live MM:SS.cc BCD time count with lap-freeze display and update/wrap strobes.
// Display lags live by one cycle; no backpressure. CHRONO_SATURATE_EN: saturate at 59:59.99.
module chrono_time_counter
   import chrono_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int TICK_HZ     = 100
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [2:0]        state,
   input  logic              reset_pulse,
   output logic [DISP_W-1:0] disp_bcd,
   output logic              running,
   output logic              frozen,
   output logic              disp_update,
   output logic              wrap
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0]                  presc;
   logic                              clear;
   logic                              counting;
   logic                              tick;
   logic                              inc_en;
   logic                              wrap_next;
   logic [N_DIGITS-1:0]               inc;
   logic [N_DIGITS-1:0]               carry;
   logic [N_DIGITS-1:0][DIGIT_W-1:0]  digits;
   time_bcd_t                         live;

   assign clear    = reset_pulse || is_clear_state(state);
   assign counting = is_counting(state) && !clear;
   assign tick     = counting && (presc == PRE_LAST);

   // Prescaler only advances while counting, so a stop keeps the partial tick.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else if (counting) begin
         presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      end
   end

`ifdef CHRONO_SATURATE_EN
   logic at_max;
   logic sat_seen;

   assign at_max    = (live == TIME_MAX);
   assign inc_en    = tick && !at_max;
   assign wrap_next = carry[N_DIGITS-1] || (tick && at_max && !sat_seen);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sat_seen <= 1'b0;
      end else if (clear) begin
         sat_seen <= 1'b0;
      end else if (tick && at_max) begin
         sat_seen <= 1'b1;
      end
   end
`else
   assign inc_en    = tick;
   assign wrap_next = carry[N_DIGITS-1];
`endif

   assign inc[0]            = inc_en;
   assign inc[N_DIGITS-1:1] = carry[N_DIGITS-2:0];
   assign live              = digits;

   bcd_digit_counter #(.MAX_DIGIT(DEC_MAX)) u_cs_u (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[0]), .digit(digits[0]), .carry(carry[0])
   );
   bcd_digit_counter #(.MAX_DIGIT(DEC_MAX)) u_cs_t (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[1]), .digit(digits[1]), .carry(carry[1])
   );
   bcd_digit_counter #(.MAX_DIGIT(DEC_MAX)) u_sec_u (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[2]), .digit(digits[2]), .carry(carry[2])
   );
   bcd_digit_counter #(.MAX_DIGIT(SEX_MAX)) u_sec_t (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[3]), .digit(digits[3]), .carry(carry[3])
   );
   bcd_digit_counter #(.MAX_DIGIT(DEC_MAX)) u_min_u (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[4]), .digit(digits[4]), .carry(carry[4])
   );
   bcd_digit_counter #(.MAX_DIGIT(SEX_MAX)) u_min_t (
      .clk_in(clk_in), .rst_in(rst_in), .clr(clear),
      .inc(inc[5]), .digit(digits[5]), .carry(carry[5])
   );

   // Display hold uses the registered lap decode, so the frozen value is live at the transition cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         running     <= 1'b0;
         frozen      <= 1'b0;
         disp_bcd    <= '0;
         disp_update <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         running <= is_counting(state);
         frozen  <= is_frozen(state);
         wrap    <= wrap_next;
         if (!frozen) begin
            disp_bcd    <= live;
            disp_update <= (live != disp_bcd);
         end else begin
            disp_update <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_chrono_time_counter.sv
// Directed bench for chrono_time_counter at DIV=10 with hand-computed expectations.
module tb_chrono_time_counter;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [2:0]  state;
   logic        reset_pulse;
   logic [23:0] disp_bcd;
   logic        running;
   logic        frozen;
   logic        disp_update;
   logic        wrap;

   int vectors     = 0;
   int miscompares = 0;
   int pulses;
   int wraps;
   int wrap_at;

`ifdef CHRONO_SATURATE_EN
   localparam logic [31:0] EXP_AFTER_WRAP = 32'h0059_5999;
   localparam logic [31:0] EXP_LATER      = 32'h0059_5999;
`else
   localparam logic [31:0] EXP_AFTER_WRAP = 32'h0000_0000;
   localparam logic [31:0] EXP_LATER      = 32'h0000_0003;
`endif

   chrono_time_counter #(
      .CLK_FREQ_HZ(1000),
      .TICK_HZ    (100)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .state      (state),
      .reset_pulse(reset_pulse),
      .disp_bcd   (disp_bcd),
      .running    (running),
      .frozen     (frozen),
      .disp_update(disp_update),
      .wrap       (wrap)
   );

   always #5 clk_in = ~clk_in;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_in      = 1'b1;
      state       = 3'd0;
      reset_pulse = 1'b0;
      cyc(2);
      chk("rst_disp",   32'(disp_bcd),    32'h0);
      chk("rst_run",    32'(running),     32'h0);
      chk("rst_frozen", 32'(frozen),      32'h0);
      chk("rst_upd",    32'(disp_update), 32'h0);
      chk("rst_wrap",   32'(wrap),        32'h0);

      // 100 running cycles give 10 ticks; display shows them one edge later
      rst_in = 1'b0;
      state  = 3'd2;
      pulses = 0;
      for (int i = 0; i < 101; i++) begin
         cyc(1);
         pulses += int'(disp_update);
      end
      chk("run_disp",   32'(disp_bcd), 32'h0000_0010);
      chk("run_pulses", 32'(pulses),   32'd10);
      chk("run_flag",   32'(running),  32'h1);

      // live reaches 00:01.23 at edge 1230, then lap for 50 cycles
      cyc(1129);
      state  = 3'd3;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         pulses += int'(disp_update);
      end
      chk("lap_disp",   32'(disp_bcd), 32'h0000_0123);
      chk("lap_frozen", 32'(frozen),   32'h1);
      chk("lap_pulses", 32'(pulses),   32'd1);

      state = 3'd2;
      cyc(2);
      chk("resume_disp",   32'(disp_bcd), 32'h0000_0128);
      chk("resume_frozen", 32'(frozen),   32'h0);

      // prescaler at 5 when stopping; resumes needing 5 more cycles
      cyc(3);
      state = 3'd1;
      cyc(200);
      chk("stop_disp", 32'(disp_bcd), 32'h0000_0128);
      chk("stop_run",  32'(running),  32'h0);
      state = 3'd2;
      cyc(5);
      chk("pre_tick_disp", 32'(disp_bcd), 32'h0000_0128);
      cyc(1);
      chk("post_tick_disp", 32'(disp_bcd),    32'h0000_0129);
      chk("post_tick_upd",  32'(disp_update), 32'h1);

      // run to 00:03.00, stop, then clear
      cyc(1709);
      state = 3'd1;
      cyc(2);
      chk("at_300_disp", 32'(disp_bcd), 32'h0000_0300);
      state       = 3'd0;
      reset_pulse = 1'b1;
      pulses      = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         pulses += int'(disp_update);
      end
      reset_pulse = 1'b0;
      chk("clr_disp",   32'(disp_bcd), 32'h0);
      chk("clr_pulses", 32'(pulses),   32'd1);
      chk("clr_run",    32'(running),  32'h0);

      // preload 59:59.99 while stopped, then let one tick elapse
      state = 3'd1;
      cyc(1);
      force dut.u_min_t.digit = 4'd5;
      force dut.u_min_u.digit = 4'd9;
      force dut.u_sec_t.digit = 4'd5;
      force dut.u_sec_u.digit = 4'd9;
      force dut.u_cs_t.digit  = 4'd9;
      force dut.u_cs_u.digit  = 4'd9;
      cyc(1);
      release dut.u_min_t.digit;
      release dut.u_min_u.digit;
      release dut.u_sec_t.digit;
      release dut.u_sec_u.digit;
      release dut.u_cs_t.digit;
      release dut.u_cs_u.digit;
      cyc(1);
      chk("max_disp", 32'(disp_bcd), 32'h0059_5999);
      state   = 3'd2;
      wraps   = 0;
      wrap_at = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (wrap) begin
            wraps++;
            wrap_at = i;
         end
      end
      chk("wrap_count", 32'(wraps),    32'd1);
      chk("wrap_cycle", 32'(wrap_at),  32'd10);
      chk("wrap_disp",  32'(disp_bcd), EXP_AFTER_WRAP);
      wraps = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         wraps += int'(wrap);
      end
      chk("wrap_again", 32'(wraps),    32'd0);
      chk("later_disp", 32'(disp_bcd), EXP_LATER);

      // rst_in in the middle of a count at 00:00.55
      state = 3'd0;
      cyc(1);
      state = 3'd2;
      cyc(551);
      chk("pre_rst_disp", 32'(disp_bcd), 32'h0000_0055);
      chk("pre_rst_run",  32'(running),  32'h1);
      rst_in = 1'b1;
      cyc(1);
      chk("mid_rst_disp",   32'(disp_bcd),    32'h0);
      chk("mid_rst_run",    32'(running),     32'h0);
      chk("mid_rst_frozen", 32'(frozen),      32'h0);
      chk("mid_rst_upd",    32'(disp_update), 32'h0);
      chk("mid_rst_wrap",   32'(wrap),        32'h0);

      // prescaler restarted: first tick needs a full 10 counting cycles
      rst_in = 1'b0;
      state  = 3'd1;
      cyc(3);
      state = 3'd2;
      cyc(10);
      chk("first_tick_early", 32'(disp_bcd), 32'h0);
      cyc(1);
      chk("first_tick_disp", 32'(disp_bcd), 32'h0000_0001);

      state = 3'd5;
      cyc(30);
      chk("st5_disp",   32'(disp_bcd), 32'h0);
      chk("st5_run",    32'(running),  32'h0);
      chk("st5_frozen", 32'(frozen),   32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
